// File: rtl/pipe_mux_pkg.sv
// Shared constants for pipe_mux: arbitration mode encodings and the
// select/channel-index width derived from the channel count.
package pipe_mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // Width of sel/out_ch/ptr: max(1, clog2(n)).
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: lowest-index requester found by searching upward from
// ptr and wrapping past N-1; purely combinational.
module rr_arbiter
  import pipe_mux_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = sel_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx,
  output logic          any
);

  int idx;

  // Walk offsets from the far end back to ptr so the nearest requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx]) begin
        grant     = N'(1) << idx;
        grant_idx = SW'(idx);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_mux.sv
// N-to-1 pipelined mux with a single-entry registered output stage, explicit
// or round-robin selection. Define PIPE_MUX_SEL_CHECK_EN for sticky sel range error.
module pipe_mux
  import pipe_mux_pkg::*;
#(
  parameter int N    = 8,
  parameter int W    = 32,
  parameter int MODE = MODE_SEL,
  localparam int SW  = sel_width(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  sel,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  input  logic           out_ready,
  output logic           sel_err
);

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_ch_q, out_ch_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic [N-1:0]  grant_oh;
  logic [SW-1:0] grant_idx;
  logic          grant_any;
  logic          can_accept;
  logic          push;
  logic [W-1:0]  sel_data;
  logic          unused_sel;

  assign unused_sel = ^sel;

  generate
    if (MODE == MODE_RR) begin : g_rr
      rr_arbiter #(.N(N), .SW(SW)) u_arb (
        .req       (in_valid),
        .ptr       (ptr_q),
        .grant     (grant_oh),
        .grant_idx (grant_idx),
        .any       (grant_any)
      );
    end else begin : g_sel
      // An out-of-range sel shifts the one-hot off the top: no grant.
      assign grant_oh  = N'(1) << sel;
      assign grant_idx = sel;
      assign grant_any = |grant_oh;
    end
  endgenerate

  assign can_accept = !out_valid_q || out_ready;
  assign in_ready   = grant_oh & {N{can_accept && grant_any && rst_n}};
  assign push       = |(in_ready & in_valid);

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (grant_oh[k]) sel_data = in_data[k*W +: W];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (push) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_ch_d    = grant_idx;
      if (MODE == MODE_RR) ptr_d = SW'((int'(grant_idx) + 1) % N);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

`ifdef PIPE_MUX_SEL_CHECK_EN
  logic sel_err_q, sel_err_d;

  assign sel_err_d = sel_err_q || ((MODE == MODE_SEL) && (int'(sel) >= N));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err_q <= 1'b0;
    else        sel_err_q <= sel_err_d;
  end

  assign sel_err = sel_err_q;
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_mux.sv
// Bench for pipe_mux: three instances (select N=8, round-robin N=8, select N=6)
// checked every cycle against a queue-free transaction model plus literal checks.
module tb_pipe_mux;
  import pipe_mux_pkg::*;

`ifdef PIPE_MUX_SEL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]   a_vld = '0, a_rdy, b_vld = '0, b_rdy;
  logic [255:0] a_data = '0, b_data = '0;
  logic [2:0]   a_sel = '0, b_sel = '0, a_ch, b_ch, c_sel = '0, c_ch;
  logic         a_ordy = 1'b1, b_ordy = 1'b1, c_ordy = 1'b1;
  logic         a_ov, b_ov, c_ov, a_err, b_err, c_err;
  logic [31:0]  a_od, b_od, c_od;
  logic [5:0]   c_vld = '0, c_rdy;
  logic [191:0] c_data = '0;

  pipe_mux #(.N(8), .W(32), .MODE(MODE_SEL)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_vld), .in_data(a_data), .in_ready(a_rdy),
    .sel(a_sel), .out_valid(a_ov), .out_data(a_od), .out_ch(a_ch), .out_ready(a_ordy),
    .sel_err(a_err));

  pipe_mux #(.N(8), .W(32), .MODE(MODE_RR)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_vld), .in_data(b_data), .in_ready(b_rdy),
    .sel(b_sel), .out_valid(b_ov), .out_data(b_od), .out_ch(b_ch), .out_ready(b_ordy),
    .sel_err(b_err));

  pipe_mux #(.N(6), .W(32), .MODE(MODE_SEL)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_vld), .in_data(c_data), .in_ready(c_rdy),
    .sel(c_sel), .out_valid(c_ov), .out_data(c_od), .out_ch(c_ch), .out_ready(c_ordy),
    .sel_err(c_err));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: what the output register holds, as a transaction-level record.
  typedef struct {
    bit          v;
    logic [31:0] d;
    int          ch;
    int          ptr;
    bit          err;
  } ms_t;

  ms_t ma, mb, mc;

  function automatic ms_t ms_reset();
    ms_t r;
    r.v = 0; r.d = '0; r.ch = 0; r.ptr = 0; r.err = 0;
    return r;
  endfunction

  function automatic void grant_of(input int mode, input int n, input int sel,
                                   input logic [7:0] vld, input int ptr,
                                   output bit ok, output int g);
    ok = 0;
    g  = 0;
    if (mode == 0) begin
      ok = (sel < n);
      g  = sel;
    end else begin
      for (int i = 0; i < n; i++) begin
        if (!ok && vld[(ptr + i) % n]) begin
          ok = 1;
          g  = (ptr + i) % n;
        end
      end
    end
  endfunction

  function automatic logic [7:0] exp_rdy(input ms_t s, input int mode, input int n,
                                         input int sel, input logic [7:0] vld, input bit ordy);
    bit ok;
    int g;
    logic [7:0] r;
    r = '0;
    grant_of(mode, n, sel, vld, s.ptr, ok, g);
    if (ok && (!s.v || ordy)) r[g] = 1'b1;
    return r;
  endfunction

  function automatic ms_t step(input ms_t s, input int mode, input int n, input int sel,
                               input logic [7:0] vld, input logic [255:0] data,
                               input bit ordy, input bit chk);
    ms_t t;
    bit ok;
    int g;
    t = s;
    grant_of(mode, n, sel, vld, s.ptr, ok, g);
    if (chk && mode == 0 && sel >= n) t.err = 1;
    if (ok && (!s.v || ordy) && vld[g]) begin
      t.v  = 1;
      t.d  = data[g*32 +: 32];
      t.ch = g;
      if (mode == 1) t.ptr = (g + 1) % n;
    end else if (s.v && ordy) begin
      t.v = 0;
    end
    return t;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma = ms_reset();
      mb = ms_reset();
      mc = ms_reset();
    end else begin
      ma = step(ma, 0, 8, int'(a_sel), a_vld, a_data, a_ordy, 1'b0);
      mb = step(mb, 1, 8, 0, b_vld, b_data, b_ordy, 1'b0);
      mc = step(mc, 0, 6, int'(c_sel), {2'b0, c_vld}, {64'b0, c_data}, c_ordy, CHK);
    end
  end

  task automatic cmp_dut(input string nm, input ms_t m, input int mode, input int n,
                         input int sel, input logic [7:0] vld, input bit ordy,
                         input logic ov, input logic [31:0] od, input int och,
                         input logic [7:0] rdy, input logic err);
    logic [7:0] er;
    er = rst_n ? exp_rdy(m, mode, n, sel, vld, ordy) : 8'h00;
    check({nm, ".out_valid"}, 64'(ov), 64'(m.v));
    if (m.v) begin
      check({nm, ".out_data"}, 64'(od), 64'(m.d));
      check({nm, ".out_ch"}, 64'(och), 64'(m.ch));
    end
    check({nm, ".in_ready"}, 64'(rdy), 64'(er));
    check({nm, ".sel_err"}, 64'(err), 64'(m.err));
  endtask

  always @(negedge clk) begin
    cmp_dut("A", ma, 0, 8, int'(a_sel), a_vld, a_ordy, a_ov, a_od, int'(a_ch), a_rdy, a_err);
    cmp_dut("B", mb, 1, 8, 0, b_vld, b_ordy, b_ov, b_od, int'(b_ch), b_rdy, b_err);
    cmp_dut("C", mc, 0, 6, int'(c_sel), {2'b0, c_vld}, c_ordy, c_ov, c_od, int'(c_ch),
            {2'b0, c_rdy}, c_err);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset: requests present but nothing may be accepted.
    a_sel = 3'd5; a_vld = 8'h20; a_data[5*32 +: 32] = 32'hDEADBEEF;
    tick(); tick();
    check("reset.a_in_ready", 64'(a_rdy), 64'h0);
    check("reset.a_out_valid", 64'(a_ov), 64'h0);
    check("reset.c_sel_err", 64'(c_err), 64'h0);
    rst_n = 1'b1;

    // Explicit select of channel 5.
    tick();
    check("sel5.out_valid", 64'(a_ov), 64'h1);
    check("sel5.out_data", 64'(a_od), 64'hDEADBEEF);
    check("sel5.out_ch", 64'(a_ch), 64'h5);
    a_vld = 8'h00;
    tick();
    check("sel5.drain", 64'(a_ov), 64'h0);
    check("sel5.ready_without_valid", 64'(a_rdy), 64'h20);

    // Backpressure for four cycles, then pop+push with no bubble.
    a_ordy = 1'b0; a_vld = 8'h20; a_data[5*32 +: 32] = 32'h11111111;
    tick();
    a_data[5*32 +: 32] = 32'h22222222;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp.hold_data", 64'(a_od), 64'h11111111);
      check("bp.in_ready", 64'(a_rdy), 64'h0);
    end
    a_ordy = 1'b1;
    tick();
    check("bp.release", 64'(a_od), 64'h22222222);
    a_data[5*32 +: 32] = 32'h33333333;
    tick();
    check("bp.no_bubble", 64'(a_od), 64'h33333333);
    check("bp.no_bubble_valid", 64'(a_ov), 64'h1);
    a_sel = 3'd2; a_vld = 8'h04; a_data[2*32 +: 32] = 32'hA5A5A5A5;
    tick();
    check("sel2.out_ch", 64'(a_ch), 64'h2);
    a_vld = 8'h00;
    tick();

    // Round robin over all eight channels.
    for (int k = 0; k < 8; k++) b_data[k*32 +: 32] = 32'hB0000000 + 32'(k);
    b_vld = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      check("rr.all_ch", 64'(b_ch), 64'(k % 8));
    end
    b_vld = 8'h44;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr.ch2_ch6", 64'(b_ch), (k % 2 == 0) ? 64'h2 : 64'h6);
    end
    b_vld = 8'h01;
    tick();
    check("rr.wrap_to_0", 64'(b_ch), 64'h0);
    b_vld = 8'h03;
    tick();
    check("rr.ptr_after_wrap", 64'(b_ch), 64'h1);
    b_ordy = 1'b0; b_vld = 8'hFF;
    tick();
    check("rr.bp_hold_ch", 64'(b_ch), 64'h1);
    check("rr.bp_in_ready", 64'(b_rdy), 64'h0);
    b_ordy = 1'b1; b_vld = 8'h00;
    tick();
    check("rr.drain", 64'(b_ov), 64'h0);

    // Out-of-range select on the six-channel instance.
    c_sel = 3'd1; c_vld = 6'h02; c_data[1*32 +: 32] = 32'hC0C0C0C1;
    tick();
    check("c.sel1_data", 64'(c_od), 64'hC0C0C0C1);
    c_sel = 3'd7; c_vld = 6'h3F;
    tick();
    check("c.sel7_in_ready", 64'(c_rdy), 64'h0);
    check("c.sel7_no_push", 64'(c_ov), 64'h0);
    check("c.sel7_err", 64'(c_err), 64'(CHK));
    c_sel = 3'd0; c_data[0 +: 32] = 32'hC0C0C0C0;
    tick();
    check("c.sel0_data", 64'(c_od), 64'hC0C0C0C0);
    check("c.err_sticky", 64'(c_err), 64'(CHK));
    c_vld = 6'h00;

    // Asynchronous reset while the output register is full.
    a_ordy = 1'b0; a_sel = 3'd5; a_vld = 8'h20; a_data[5*32 +: 32] = 32'h55555555;
    tick();
    check("arst.pre_valid", 64'(a_ov), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.out_valid", 64'(a_ov), 64'h0);
    check("arst.out_data", 64'(a_od), 64'h0);
    check("arst.out_ch", 64'(a_ch), 64'h0);
    check("arst.sel_err", 64'(c_err), 64'h0);
    check("arst.in_ready", 64'(a_rdy), 64'h0);
    a_vld = 8'h00; a_ordy = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("arst.no_spurious_push", 64'(a_ov), 64'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_mux.md
PIPE_MUX -- requirements
Module: pipe_mux

Interface
REQ-001 Parameter N, default 8, number of input channels (2..32).
REQ-002 Parameter W, default 32, data width per channel (1..64).
REQ-003 Parameter MODE, default 0: 0 = explicit select via sel, 1 = round-robin arbitration.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  N  per-channel data valid.
REQ-007 in_data  input  N*W  channel k occupies bits [k*W +: W].
REQ-008 in_ready  output  N  per-channel accept; at most one bit high per cycle.
REQ-009 sel  input  SW=max(1,clog2(N))  channel select; used only when MODE=0.
REQ-010 out_valid  output  1  output register holds data.
REQ-011 out_data  output  W  registered selected data.
REQ-012 out_ch  output  SW  index of the channel that supplied out_data.
REQ-013 out_ready  input  1  downstream accept.
REQ-014 sel_err  output  1  sticky out-of-range select flag (see REQ-030).

Function
REQ-015 Single-entry output register; transfer upstream when in_valid[g] && in_ready[g], where g is the granted channel.
REQ-016 in_ready[g] SHALL equal (!out_valid || out_ready) and grant valid; all other in_ready bits 0.
REQ-017 Latency one cycle: data accepted in cycle t appears on out_data with out_valid in cycle t+1.
REQ-018 Simultaneous pop (out_valid && out_ready) and push SHALL sustain one transfer per cycle with no bubble.
REQ-019 While out_valid && !out_ready, out_data and out_ch SHALL hold stable and no channel is accepted.
REQ-020 out_valid clears after a pop with no simultaneous push.
REQ-021 MODE=0: g = sel; in_ready[sel] depends only on output-stage state, not on in_valid[sel].
REQ-022 MODE=1: g = lowest-index channel with in_valid high, searching from ptr upward and wrapping past N-1 to 0.
REQ-023 MODE=1: ptr (SW bits) SHALL advance to (g+1) mod N only on an accepted transfer; unchanged otherwise.
REQ-024 MODE=1: no valid channel -> no grant, all in_ready 0, ptr unchanged.
REQ-025 MODE=1: in_ready[g] may depend combinationally on in_valid; no combinational path from in_data to any output.

Reset
REQ-026 rst_n low asynchronously clears out_valid, out_data, out_ch, ptr and sel_err to 0.
REQ-027 Reset mid-transfer discards held data; no transfer occurs in the first rising edge after rst_n deasserts unless inputs request it.
REQ-028 in_ready SHALL be 0 for all channels while rst_n is low.

Configuration
REQ-029 Macro PIPE_MUX_SEL_CHECK_EN enables select range checking (MODE=0 only).
REQ-030 Defined: sel >= N forces all in_ready to 0 and sets sel_err on that edge; sel_err stays high until reset.
REQ-031 Undefined: sel_err tied 0; sel >= N yields no grant (all in_ready 0), no flag.

Structure
REQ-032 Package pipe_mux_pkg SHALL hold MODE constants (MODE_SEL=0, MODE_RR=1) and the select-width calculation.
REQ-033 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs req[N], ptr; outputs grant one-hot, grant index, any).

Verification
REQ-034 MODE=0, N=8, W=32: sel=5, in_valid[5]=1, in_data ch5=0xDEADBEEF, out_ready=1 -> next cycle out_valid=1, out_data=0xDEADBEEF, out_ch=5.
REQ-035 Backpressure: out_valid=1, out_ready=0 for 4 cycles -> out_data constant, in_ready all 0; out_ready=1 with new push -> next word on following cycle, no gap.
REQ-036 MODE=1, all 8 channels valid continuously, out_ready=1 -> out_ch sequence 0,1,...,7,0; channels 2 and 6 only valid -> 2,6,2,6.
REQ-037 MODE=1 wrap: ptr=7, only ch0 valid -> grant 0, ptr becomes 1.
REQ-038 N=6, macro defined, sel=7 -> in_ready all 0, sel_err=1 after edge and held; undefined -> sel_err stays 0.
REQ-039 Assert rst_n low while out_valid=1 -> out_valid, out_data, out_ch, sel_err drop to 0 immediately without clock edge.
